fetch_redirect: RTL and testbench
=================================

// Module: fetch_redirect
// PURPOSE
//  Consumer end of the execute-stage branch decision: owns the PC and the instruction-memory fetch.
//  Takes br_taken/br_target from execute and redirects fetch.
//  Kills the buffered instruction and any in-flight response when a redirect occurs.
//  Sits between imem and decode.
//  Single outstanding imem request; one-entry instruction buffer toward decode.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  NOP_INST   32'h0000_0013  value driven on inst when buffer empty/flushed (addi x0,x0,0)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  ex_valid     in   1   execute holds a valid instruction this cycle
//  br_taken     in   1   branch/jal/jalr resolved taken (qualified by ex_valid)
//  br_target    in   32  taken target (pc+imm or rs1+imm)
//  stall        in   1   decode cannot accept inst this cycle
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  fetch address, word aligned
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   response data valid (>=1 cycle after gnt)
//  imem_rdata   in   32  response instruction word
//  inst         out  32  instruction to decode
//  inst_valid   out  1   inst is valid
//  inst_pc      out  32  PC of inst
//  flush        out  1   one-cycle pulse: younger instructions killed
//  misalign     out  1   sticky: taken target had bit1 set; fetch halted
// BEHAVIOUR
//  Reset:
//   - state=S_REQ, pc_q=RESET_PC, imem_req=0 during rst.
//   - inst_valid=0, inst=NOP_INST, inst_pc=0, flush=0, misalign=0, discard_q=0.
//  States S_REQ, S_WAIT, S_TRAP. redirect = ex_valid & br_taken.
//  S_REQ:
//   - imem_req=1 when !(inst_valid & stall) & !redirect; imem_addr=pc_q.
//   - gnt -> S_WAIT, fetch_pc_q<=pc_q.
//  S_WAIT:
//   - imem_req=0.
//   - rvalid & !discard_q: inst<=rdata, inst_pc<=fetch_pc_q, inst_valid<=1, pc_q<=fetch_pc_q+4 (mod 2^32), -> S_REQ.
//   - rvalid & discard_q: response dropped, discard_q<=0, -> S_REQ.
//  Buffer:
//   - inst/inst_pc/inst_valid hold while stall=1.
//   - !stall & no new response -> inst_valid<=0, inst<=NOP_INST.
//  Redirect (priority over stall and over a same-cycle rvalid), if br_target[1]==0:
//   - pc_q<=br_target & ~32'h1 (bit0 cleared, jalr rule).
//   - inst_valid<=0, inst<=NOP_INST, flush<=1 next cycle only.
//   - in S_WAIT, or S_REQ with gnt same cycle: discard_q<=1, state S_WAIT.
//   - same-cycle rvalid in S_WAIT: the response is dropped and discard_q stays 0.
//   - first request to new pc_q issued the cycle after redirect at the earliest.
//  Redirect with br_target[1]==1:
//   - misalign<=1, flush<=1 pulse, inst_valid<=0.
//   - state -> S_TRAP; outstanding response still drained and dropped.
//   - S_TRAP: imem_req=0, exits only on rst.
//  Back-to-back redirects: the latest target wins; discard_q never exceeds one outstanding response.
//  rst mid-transaction returns to S_REQ; a late rvalid after reset is ignored (S_REQ ignores rvalid).
//  Latency: no-wait imem (rvalid the cycle after gnt) yields inst_valid 2 cycles after req, 1 instr/2 cycles.
// STRUCTURE
//  Shared core package:
//   - typedef enum logic[1:0] fetch_state_e {S_REQ,S_WAIT,S_TRAP}.
//   - localparams NOP_INST, OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111.
//  One sub-module: fetch_inst_buf (one-entry buffer with hold/flush); FSM and PC stay in top.
// TESTING
//  1 Reset: rst 2 cycles, then release; zero-wait imem.
//    -> imem_addr 0x0, 0x4, 0x8 on successive reqs; inst_pc matches; flush=0.
//  2 Stall: inst_valid=1 at pc 0x8, stall=1 for 3 cycles.
//    -> inst/inst_pc held, imem_req=0, no pc advance; release -> req at 0xC.
//  3 Redirect in S_WAIT: req 0x10 granted, rvalid delayed 3 cycles; br_taken, target 0x100.
//    -> flush pulse 1 cycle; 0x10 data dropped; next imem_addr 0x100.
//  4 jalr target: br_target=0x201.
//    -> next imem_addr 0x200, inst_pc 0x200.
//  5 Misaligned target: br_target=0x302.
//    -> misalign=1 sticky, imem_req stays 0 until rst; rst clears misalign and restarts at RESET_PC.
//  6 Simultaneous: redirect + stall + rvalid in the same cycle.
//    -> buffer cleared, rdata dropped, inst=NOP_INST; next fetch from target.

Source files
------------

// File: rtl/fetch_redirect_pkg.sv
// Shared fetch-stage types and constants.
package fetch_redirect_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_inst_buf.sv
// One-entry instruction buffer toward decode: load, hold on stall, flush.
module fetch_inst_buf #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  // Flush beats a new response; otherwise load, hold on stall, or drain to NOP.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
    end else if (!stall) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign inst_valid = valid_q;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// redirects on taken branches from execute, killing stale work.
module fetch_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_redirect_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic        flush,
  output logic        misalign
);
  import fetch_redirect_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         discard_q, discard_d;
  logic         flush_q, flush_d;
  logic         misalign_q, misalign_d;
  logic         redirect;
  logic         buf_load, buf_flush;

  assign redirect = ex_valid & br_taken;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      discard_q  <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  // Next state: a redirect outside S_TRAP overrides normal fetch progress.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    flush_d    = 1'b0;
    misalign_d = misalign_q;
    buf_load   = 1'b0;
    buf_flush  = 1'b0;
    if (redirect && state_q != S_TRAP) begin
      flush_d   = 1'b1;
      buf_flush = 1'b1;
      if (br_target[1]) begin
        misalign_d = 1'b1;
        discard_d  = 1'b0;
        state_d    = S_TRAP;
      end else begin
        pc_d = br_target & ~32'h1;
        // A same-cycle response is the stale one: drop it, nothing left to discard.
        if (state_q == S_WAIT) begin
          discard_d = !imem_rvalid;
          state_d   = imem_rvalid ? S_REQ : S_WAIT;
        end else if (imem_gnt) begin
          discard_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req && imem_gnt) begin
            fetch_pc_d = pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else begin
              buf_load = 1'b1;
              pc_d     = fetch_pc_q + 32'd4;
            end
            state_d = S_REQ;
          end
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Outputs: request only when the buffer can take the result and no redirect.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (!rst && state_q == S_REQ && !(inst_valid && stall) && !redirect) begin
      imem_req = 1'b1;
    end
  end

  assign flush    = flush_q;
  assign misalign = misalign_q;

  fetch_inst_buf #(
    .NOP_INST (NOP_INST)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .flush      (buf_flush),
    .stall      (stall),
    .load_inst  (imem_rdata),
    .load_pc    (fetch_pc_q),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed cycle table plus randomized run
// against a transaction-level model of fetch/redirect behaviour.
module tb_fetch_redirect;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, ex_valid, br_taken, stall;
  logic [31:0] br_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, flush, misalign;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_redirect dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .flush       (flush),
    .misalign    (misalign)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ex;
    logic [31:0] tgt;
    logic        stall, gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic        e_fl, e_mis;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic ex, input logic [31:0] tgt,
                              input logic st, input logic g, input logic rv,
                              input logic [31:0] rd, input logic e_req,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_ipc, input logic e_fl, input logic e_mis);
    vec_t v;
    v.rst = r; v.ex = ex; v.tgt = tgt; v.stall = st; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
    v.e_fl = e_fl; v.e_mis = e_mis;
    return v;
  endfunction

  // Randomized-phase model state
  logic [31:0] m_pc, m_inst, m_ipc, out_addr, pc_pre, r_tgt;
  logic        m_iv, m_fl, busy, r_stall, r_rv, rd, g, exp_req, deliver;
  int          epoch, out_ep, lat, n_del;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; br_taken = 1'b0; br_target = '0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // rst ex tgt stall gnt rv rdata | req addr iv ipc flush mis
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h000,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h000),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h004,1,32'h000,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h004),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h008,1,32'h004,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h008),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0,               0,0,1,32'h008,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0,               0,0,1,32'h008,0,0));
    vt.push_back(mk(0,0,0,1,0,0,0,               0,0,1,32'h008,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h00C,1,32'h008,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h00C),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h010,1,32'h00C,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0,0,0));
    vt.push_back(mk(0,1,32'h100,0,0,0,0,         0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h010),    0,0,0,0,1,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h100,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h100),    0,0,0,0,0,0));
    vt.push_back(mk(0,1,32'h201,0,0,0,0,         0,0,1,32'h100,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h200,0,0,1,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h200),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h204,1,32'h200,0,0));
    vt.push_back(mk(0,1,32'h400,1,0,1,mem(32'h204), 0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h400,0,0,1,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h400),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,               1,32'h404,1,32'h400,0,0));
    vt.push_back(mk(0,1,32'h302,0,0,0,0,         0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,               0,0,0,0,1,1));
    vt.push_back(mk(0,0,0,0,1,0,0,               0,0,0,0,0,1));
    vt.push_back(mk(1,0,0,0,0,0,0,               0,0,0,0,0,1));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h000,0,0,0,0));
    vt.push_back(mk(1,0,0,0,0,0,0,               0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,32'hBAD0_BAD0,   1,32'h000,0,0,0,0));
    vt.push_back(mk(0,0,0,0,1,0,0,               1,32'h000,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,1,mem(32'h000),    0,0,0,0,0,0));
    vt.push_back(mk(0,0,0,0,0,0,0,               1,32'h004,1,32'h000,0,0));

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_misalign", misalign, 0);

    // Directed cycle table
    foreach (vt[i]) begin
      rst = vt[i].rst; ex_valid = vt[i].ex; br_taken = vt[i].ex; br_target = vt[i].tgt;
      stall = vt[i].stall; imem_gnt = vt[i].gnt; imem_rvalid = vt[i].rv;
      imem_rdata = vt[i].rdata;
      #1;
      chk($sformatf("vec%0d_req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_iv", i), inst_valid, vt[i].e_iv);
      chk($sformatf("vec%0d_inst", i), inst, vt[i].e_iv ? mem(vt[i].e_ipc) : NOP);
      if (vt[i].e_iv) chk($sformatf("vec%0d_ipc", i), inst_pc, vt[i].e_ipc);
      chk($sformatf("vec%0d_flush", i), flush, vt[i].e_fl);
      chk($sformatf("vec%0d_mis", i), misalign, vt[i].e_mis);
      @(posedge clk); #1;
    end

    // Randomized run against the transaction-level model
    rst = 1'b1; ex_valid = 1'b0; br_taken = 1'b0; stall = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 32'h0; m_iv = 1'b0; m_fl = 1'b0; m_inst = NOP; m_ipc = '0;
    busy = 1'b0; epoch = 0; out_ep = 0; lat = 0; n_del = 0; out_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_iv", inst_valid, m_iv);
      chk("rnd_inst", inst, m_iv ? m_inst : NOP);
      if (m_iv) chk("rnd_ipc", inst_pc, m_ipc);
      chk("rnd_flush", flush, m_fl);
      chk("rnd_mis", misalign, 0);

      r_stall   = ($urandom_range(0, 2) == 0);
      ex_valid  = $urandom_range(0, 1) == 1;
      br_taken  = ($urandom_range(0, 4) == 0);
      rd        = ex_valid & br_taken;
      r_tgt     = $urandom & 32'hFFFF_FFFD;
      r_rv      = busy && (lat == 0);
      stall     = r_stall;
      br_target = r_tgt;
      imem_rvalid = r_rv;
      imem_rdata  = r_rv ? mem(out_addr) : $urandom;
      imem_gnt    = 1'b0;
      #1;
      exp_req = !busy && !(m_iv && r_stall) && !rd;
      chk("rnd_req", imem_req, exp_req);
      if (exp_req) chk("rnd_addr", imem_addr, m_pc);
      g = exp_req && ($urandom_range(0, 2) != 0);
      imem_gnt = g;

      pc_pre = m_pc;
      m_fl = rd;
      if (rd) begin
        epoch++;
        m_pc = r_tgt & ~32'h1;
      end
      deliver = r_rv && (out_ep == epoch);
      if (r_rv) busy = 1'b0;
      else if (busy) lat--;
      if (rd) m_iv = 1'b0;
      else if (deliver) begin
        m_iv = 1'b1; m_inst = mem(out_addr); m_ipc = out_addr;
        m_pc = out_addr + 32'd4; n_del++;
      end else if (!r_stall) m_iv = 1'b0;
      if (g) begin
        busy = 1'b1; out_addr = pc_pre; out_ep = epoch; lat = $urandom_range(0, 3);
      end
      @(posedge clk); #1;
    end
    chk("rnd_progress", n_del > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
